fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NREQ producers take turns writing into one
// shared FIFO. A producer is granted for a burst of up to BURST_MAX beats; the
// burst ends early when the owner drops valid. A full FIFO stalls the burst
// without losing ownership. One IDLE cycle separates bursts and is used for
// arbitration.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   req_valid    in   [NREQ]     producer i has a beat to offer
//   req_data     in   [NREQ*DW]  producer i data in slice [i*DW +: DW]
//   req_ready    out  [NREQ]     producer i's beat is accepted this cycle
//   fifo_full    in   shared FIFO full flag
//   fifo_wr_en   out  FIFO write strobe
//   fifo_din     out  [DW]       FIFO write data (0 while idle)
//   grant_active out  a burst is in progress
//   grant_id     out  [2]        current or most recent owner
//   xfer_total   out  [16]       saturating count of accepted beats
//
// The owner fields are 2 bits wide, so NREQ is fixed at 4 for this revision.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [DW-1:0]      fifo_din,
    output logic               grant_active,
    output logic [1:0]         grant_id,
    output logic [15:0]        xfer_total
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0]  BURST_LAST = 4'(BURST_MAX);
    localparam logic [15:0] TOTAL_MAX  = 16'hFFFF;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_owner_q, last_owner_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [15:0] xfer_total_q, xfer_total_d;

    logic        in_grant;
    logic        owner_valid;
    logic        xfer;
    logic [3:0]  beat_inc;
    logic        pick_found;
    logic [1:0]  pick_id;
    logic [1:0]  cand;

    assign in_grant    = (state_q == ST_GRANT);
    assign owner_valid = req_valid[owner_q];
    // A beat moves only while the owner offers data and the FIFO has room.
    assign xfer        = in_grant && owner_valid && !fifo_full;
    assign beat_inc    = beat_cnt_q + 4'd1;

    // Round-robin pick: scan upward starting just after the previous owner.
    // The 2-bit add wraps modulo 4, and k == NREQ revisits last_owner itself
    // so a lone requester can be re-granted.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        pick_found = 1'b0;
        pick_id    = 2'd0;
        cand       = 2'd0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last_owner_q + 2'(k);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        xfer_total_d = xfer_total_q;

        if (xfer && (xfer_total_q != TOTAL_MAX)) begin
            xfer_total_d = xfer_total_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_id;
                    beat_cnt_d = 4'd0;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    beat_cnt_d = beat_inc;
                end
                // Release when the owner goes quiet (even while stalled on a
                // full FIFO) or when this beat completes the burst.
                if (!owner_valid || (xfer && (beat_inc == BURST_LAST))) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd3;   // producer 0 has first priority
            beat_cnt_q   <= 4'd0;
            xfer_total_q <= 16'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge value of its neighbours.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            xfer_total_q <= xfer_total_d;
        end
    end

    // Handshake outputs are combinational so a beat is accepted in the same
    // cycle it is offered; the async reset clears the state and so forces
    // them to 0 immediately.
    always_comb begin
        req_ready = '0;
        if (in_grant && !fifo_full) begin
            req_ready[owner_q] = 1'b1;
        end
    end

    assign fifo_wr_en   = xfer;
    assign fifo_din     = in_grant ? req_data[int'(owner_q) * DW +: DW] : '0;
    assign grant_active = in_grant;
    assign grant_id     = owner_q;
    assign xfer_total   = xfer_total_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter. A driver applies one cycle of
// stimulus at a time and steps a transaction-level reference model: the model
// tracks "who owns the FIFO and how many beats remain", and for every beat it
// predicts it pushes the expected write into a scoreboard queue. A separate
// monitor samples the DUT on the falling edge and pops/compares whenever the
// DUT writes. Directed sequences cover the documented scenarios; a randomized
// run covers the rest.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int BURST_MAX = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic [15:0] xfer_total;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .xfer_total   (xfer_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard entry: the cycle a write is due, its data and its owner.
    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        int          owner;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;

    // Reference model: grant held (m_active) by m_owner with m_left beats
    // still allowed; m_prio is the producer searched first next time.
    bit m_active;
    int m_owner;
    int m_prio;
    int m_left;
    int m_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_owner  = 0;
        m_prio   = 0;
        m_left   = 0;
        m_total  = 0;
    endtask

    // One cycle of the model: check the DUT state the model believes in,
    // predict this cycle's write, then advance to the next cycle.
    task automatic model_step(input logic [3:0] v, input logic [31:0] d, input logic full);
        logic [3:0] exp_ready;
        exp_t       e;
        exp_ready = 4'b0000;
        if (m_active && !full) exp_ready[m_owner] = 1'b1;
        check("grant_active", 32'(grant_active), 32'(m_active));
        check("grant_id",     32'(grant_id),     32'(m_owner));
        check("req_ready",    32'(req_ready),    32'(exp_ready));
        check("xfer_total",   32'(xfer_total),   32'(m_total));

        if (m_active && v[m_owner] && !full) begin
            e.cyc   = cyc;
            e.data  = d[m_owner*8 +: 8];
            e.owner = m_owner;
            exp_q.push_back(e);
            m_left--;
            if (m_total < 65535) m_total++;
        end

        if (m_active) begin
            if (!v[m_owner] || m_left == 0) begin
                m_active = 1'b0;
                m_prio   = (m_owner + 1) % 4;
            end
        end else if (v != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_prio + k) % 4;
                if (v[c]) begin
                    m_owner  = c;
                    m_active = 1'b1;
                    m_left   = BURST_MAX;
                    break;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, then run the model against it.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic full);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = v;
        req_data  = d;
        fifo_full = full;
        cyc++;
        #1;
        model_step(v, d, full);
    endtask

    // Hold reset for n cycles (inputs untouched); outputs must read 0 at once.
    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            cyc++;
            #1;
            check("rst_req_ready",    32'(req_ready),    32'd0);
            check("rst_fifo_wr_en",   32'(fifo_wr_en),   32'd0);
            check("rst_fifo_din",     32'(fifo_din),     32'd0);
            check("rst_grant_active", 32'(grant_active), 32'd0);
            check("rst_grant_id",     32'(grant_id),     32'd0);
            check("rst_xfer_total",   32'(xfer_total),   32'd0);
        end
        model_reset();
    endtask

    // Monitor: pops the scoreboard whenever a write is due or happens.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            check("no_wr_when_full", 32'(fifo_wr_en & fifo_full), 32'd0);
            check("ready_onehot0",   32'($onehot0(req_ready)),    32'd1);
            check("wr_en_handshake", 32'(fifo_wr_en), 32'(|(req_valid & req_ready)));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("sb_stale_write", exp_q[0].cyc, cyc);
                exp_q.delete(0);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("sb_wr_en",  32'(fifo_wr_en), 32'd1);
                check("sb_din",    32'(fifo_din),   32'(e.data));
                check("sb_ready",  32'(req_ready),  32'd1 << e.owner);
            end else begin
                check("sb_no_wr",  32'(fifo_wr_en), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish in time (checks=%0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

    // All four valid from reset: 0 first, 4 beats, one gap, then producer 1.
    task automatic test_basic();
        logic [7:0] exp_din [11] = '{8'h00, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'h00,
                                     8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'h00};
        apply_reset(2);
        for (int i = 0; i < 11; i++) begin
            cycle(4'hF, 32'hA3A2_A1A0, 1'b0);
            check("basic_wr_en", 32'(fifo_wr_en), 32'(exp_din[i] != 8'h00));
            check("basic_din",   32'(fifo_din),   32'(exp_din[i]));
        end
        check("basic_total", 32'(xfer_total), 32'd8);
    endtask

    // Producer 2 alone for 10 beats: bursts 4,4,2 with one-cycle gaps.
    task automatic test_solo();
        bit         wr_pat [13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
        int         beat;
        logic [7:0] dat;
        beat = 0;
        apply_reset(1);
        for (int i = 0; i < 13; i++) begin
            dat = 8'h20 + 8'(beat);
            cycle(4'b0100, {8'h00, dat, 16'h0000}, 1'b0);
            check("solo_wr_en", 32'(fifo_wr_en), 32'(wr_pat[i]));
            if (i > 0) check("solo_grant_id", 32'(grant_id), 32'd2);
            if (wr_pat[i]) begin
                check("solo_din", 32'(fifo_din), 32'(dat));
                beat++;
            end
        end
        cycle(4'b0000, 32'h0, 1'b0);
        check("solo_drop_active", 32'(grant_active), 32'd1);
        check("solo_drop_wr_en",  32'(fifo_wr_en),   32'd0);
        cycle(4'b0000, 32'h0, 1'b0);
        check("solo_idle_active", 32'(grant_active), 32'd0);
        check("solo_idle_id",     32'(grant_id),     32'd2);
    endtask

    // Producer 1, FIFO full for 3 cycles after beat 2.
    task automatic test_stall();
        bit         full_pat [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        bit         wr_pat   [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        bit         act_pat  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        int         beat;
        logic [7:0] dat;
        beat = 0;
        apply_reset(1);
        for (int i = 0; i < 9; i++) begin
            dat = 8'h10 + 8'(beat);
            cycle(4'b0010, {16'h0000, dat, 8'h00}, full_pat[i]);
            check("stall_wr_en",  32'(fifo_wr_en),   32'(wr_pat[i]));
            check("stall_ready",  32'(req_ready),    wr_pat[i] ? 32'h2 : 32'h0);
            check("stall_active", 32'(grant_active), 32'(act_pat[i]));
            if (i > 0) check("stall_grant_id", 32'(grant_id), 32'd1);
            if (wr_pat[i]) begin
                check("stall_din", 32'(fifo_din), 32'(dat));
                beat++;
            end
        end
    endtask

    // After producer 1's burst, 4'b1001 must grant 3 before 0.
    task automatic test_rr_wrap();
        apply_reset(1);
        for (int i = 0; i < 12; i++) begin
            cycle((i < 5) ? 4'b0010 : 4'b1001, 32'hD3D2_D1D0, 1'b0);
            if (i == 5) check("wrap_gap_active", 32'(grant_active), 32'd0);
            if (i == 6) begin
                check("wrap_first_id",  32'(grant_id), 32'd3);
                check("wrap_first_din", 32'(fifo_din), 32'hD3);
            end
            if (i == 11) begin
                check("wrap_second_id",  32'(grant_id), 32'd0);
                check("wrap_second_din", 32'(fifo_din), 32'hD0);
            end
        end
    endtask

    // Reset during beat 2 of producer 3; afterwards producer 0 goes first.
    task automatic test_mid_reset();
        apply_reset(1);
        cycle(4'b1000, 32'hE3E2_E1E0, 1'b0);
        cycle(4'b1000, 32'hE3E2_E1E0, 1'b0);
        check("midrst_beat1_id",  32'(grant_id), 32'd3);
        check("midrst_beat1_din", 32'(fifo_din), 32'hE3);
        apply_reset(2);
        cycle(4'b1001, 32'hE3E2_E1E0, 1'b0);
        check("midrst_arb_active", 32'(grant_active), 32'd0);
        cycle(4'b1001, 32'hE3E2_E1E0, 1'b0);
        check("midrst_restart_id",  32'(grant_id),   32'd0);
        check("midrst_restart_din", 32'(fifo_din),   32'hE0);
        check("midrst_restart_wr",  32'(fifo_wr_en), 32'd1);
    endtask

    // Preload the counter to 16'hFFFE, then 3 transfers must stop at 16'hFFFF.
    task automatic test_saturate();
        apply_reset(1);
        cycle(4'b0000, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        force dut.xfer_total_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.xfer_total_q;
        m_total = 32'hFFFE;
        for (int i = 0; i < 6; i++) begin
            cycle((i < 4) ? 4'b0001 : 4'b0000, 32'h0000_00F0, 1'b0);
            if (i == 0) check("sat_preload", 32'(xfer_total), 32'hFFFE);
            if (i >= 4) check("sat_total",   32'(xfer_total), 32'hFFFF);
        end
    endtask

    // Randomized traffic, with stretches of all-valid/never-full traffic.
    task automatic test_random(input int n);
        logic [3:0]  v;
        logic [31:0] d;
        logic        f;
        apply_reset(1);
        for (int i = 0; i < n; i++) begin
            if (((i / 400) % 3) == 2) begin
                v = 4'hF;
                f = 1'b0;
            end else begin
                for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 9) < 7);
                f = ($urandom_range(0, 4) == 0);
            end
            d = $urandom();
            if ($urandom_range(0, 999) == 0) apply_reset(1);
            else cycle(v, d, f);
        end
    endtask

    initial begin : main
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        fifo_full = 1'b0;
        model_reset();

        test_basic();
        test_solo();
        test_stall();
        test_rr_wrap();
        test_mid_reset();
        test_saturate();
        test_random(3000);

        for (int i = 0; i < 3; i++) cycle(4'b0000, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        check("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
